data_mem_responder: RTL and testbench

Data-memory responder at the MEM stage of the pipelined CPU. Services the load/store requests the control path issues through the EX/MEM register (`MEM_EN_MEM`, `MEM_RW`, `MEM_size`). Accesses are byte, halfword or word on a big-endian byte array, with a programmable number of wait states. While an access is in flight it holds the pipeline with `stall`, and it signals completion with a one-cycle `done` pulse.

---
 rtl/data_mem_if.sv | 29 ++
 rtl/data_mem_responder.sv | 162 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: load/store request and response bundle between the MEM-stage
// control path (master) and the data-memory responder (slave).
//   MEM_EN_MEM  request strobe        MEM_RW    1 = store, 0 = load
//   MEM_size    00 byte / 01 half / 1x word
//   address     byte address          data_in   store data (low bytes for narrow)
//   data_out    zero-extended load result
//   stall       pipeline hold         done      one-cycle completion pulse
//   fault       misaligned-access flag (0 unless the alignment check is built in)
interface data_mem_if;
    logic        MEM_EN_MEM;
    logic        MEM_RW;
    logic [1:0]  MEM_size;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (
        output MEM_EN_MEM, MEM_RW, MEM_size, address, data_in,
        input  data_out, stall, done, fault
    );

    modport slave (
        input  MEM_EN_MEM, MEM_RW, MEM_size, address, data_in,
        output data_out, stall, done, fault
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: MEM-stage data memory. Big-endian byte array serving
// byte/halfword/word loads and stores with WAIT_CYCLES wait states. Holds the
// pipeline with stall while busy and pulses done when the access completes.
// Ports:
//   Clk  clock, rising edge
//   R    synchronous active-high reset
//   bus  data_mem_if.slave (request in, data_out/stall/done/fault out)
// Parameters: DEPTH (bytes, power of two >= 4), WAIT_CYCLES (0..15).
// Build option: define DATA_MEM_ALIGN_CHECK_EN to suppress misaligned
// accesses and flag them on fault; otherwise misaligned accesses wrap and
// fault is tied low.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic      Clk,
    input  logic      R,
    data_mem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    logic [7:0]    Memory [0:DEPTH-1];

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          rw_q;
    logic [31:0]   data_out_q;
    logic          done_q;

    logic          misaligned_c;
    logic [31:0]   rd_word_c;
    logic [31:0]   load_val_c;
    logic [31:0]   wr_word_c;
    logic [3:0]    be_c;

    // Only the low AW address bits select a byte.
    logic          unused_addr;
    assign unused_addr = ^bus.address[31:AW];

`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic          fault_q;
    assign misaligned_c = ((size_q == 2'b01) && addr_q[0]) ||
                          (size_q[1] && (addr_q[1:0] != 2'b00));
    assign bus.fault    = fault_q;
`else
    assign misaligned_c = 1'b0;
    assign bus.fault    = 1'b0;
`endif

    // Four bytes starting at the latched address, big-endian, index wrapping.
    always_comb begin
        rd_word_c = '0;
        for (int i = 0; i < 4; i++) begin
            rd_word_c[31-8*i -: 8] = Memory[AW'(addr_q + AW'(i))];
        end
    end

    // Narrow loads take the leading bytes; narrow stores put the low bytes of
    // the store data in the leading byte lanes.
    always_comb begin
        case (size_q)
            2'b00: begin
                load_val_c = {24'h0, rd_word_c[31:24]};
                wr_word_c  = {wdata_q[7:0], 24'h0};
                be_c       = 4'b1000;
            end
            2'b01: begin
                load_val_c = {16'h0, rd_word_c[31:16]};
                wr_word_c  = {wdata_q[15:0], 16'h0};
                be_c       = 4'b1100;
            end
            default: begin
                load_val_c = rd_word_c;
                wr_word_c  = wdata_q;
                be_c       = 4'b1111;
            end
        endcase
    end

    // Store commit on the ACCESS edge; reset wins, memory itself is never cleared.
    always_ff @(posedge Clk) begin
        if (!R && (state == S_ACCESS) && rw_q && !misaligned_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[3-i]) begin
                    Memory[AW'(addr_q + AW'(i))] <= wr_word_c[31-8*i -: 8];
                end
            end
        end
    end

    // Access sequencer: IDLE -> WAIT (WAIT_CYCLES cycles) -> ACCESS -> DONE.
    always_ff @(posedge Clk) begin
        if (R) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.MEM_EN_MEM) begin
                        addr_q   <= bus.address[AW-1:0];
                        wdata_q  <= bus.data_in;
                        size_q   <= bus.MEM_size;
                        rw_q     <= bus.MEM_RW;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_ACCESS: begin
                    if (!rw_q && !misaligned_c) begin
                        data_out_q <= load_val_c;
                    end
                    done_q  <= 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                    fault_q <= misaligned_c;
`endif
                    state   <= S_DONE;
                end
                S_DONE: begin
                    // Requests seen here wait for the following IDLE cycle.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.stall    = !R && (((state == S_IDLE) && bus.MEM_EN_MEM) ||
                                 (state == S_WAIT) || (state == S_ACCESS));
    assign bus.done     = done_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: two responders (WAIT_CYCLES=1 and 0) driven one at a
// time from shared stimulus; a byte-array model predicts memory, data_out and
// the per-cycle stall/done/fault pattern of each transaction.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 256;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        R;
    logic        en;
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] din;
    int          sel;

    data_mem_if bus_a ();
    data_mem_if bus_b ();

    assign bus_a.MEM_EN_MEM = en && (sel == 0);
    assign bus_a.MEM_RW     = rw;
    assign bus_a.MEM_size   = size;
    assign bus_a.address    = addr;
    assign bus_a.data_in    = din;
    assign bus_b.MEM_EN_MEM = en && (sel == 1);
    assign bus_b.MEM_RW     = rw;
    assign bus_b.MEM_size   = size;
    assign bus_b.address    = addr;
    assign bus_b.data_in    = din;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut_a (
        .Clk (Clk),
        .R   (R),
        .bus (bus_a)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .Clk (Clk),
        .R   (R),
        .bus (bus_b)
    );

    logic        o_stall, o_done, o_fault;
    logic [31:0] o_dout;
    assign o_stall = (sel == 0) ? bus_a.stall    : bus_b.stall;
    assign o_done  = (sel == 0) ? bus_a.done     : bus_b.done;
    assign o_fault = (sel == 0) ? bus_a.fault    : bus_b.fault;
    assign o_dout  = (sel == 0) ? bus_a.data_out : bus_b.data_out;

    // Model state
    logic [7:0]  mem_m  [2][DEPTH];
    logic [31:0] dout_m [2];

    logic        exp_stall, exp_done, exp_fault;
    logic [31:0] exp_dout;
    bit          chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            check32("stall",    32'(o_stall), 32'(exp_stall));
            check32("done",     32'(o_done),  32'(exp_done));
            check32("fault",    32'(o_fault), 32'(exp_fault));
            check32("data_out", o_dout,       exp_dout);
        end
    end

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] s, input logic [31:0] a);
        return ALIGN && (((s == 2'b01) && a[0]) || (s[1] && (a[1:0] != 2'b00)));
    endfunction

    task automatic model_access(input int d, input bit r_w, input logic [1:0] s,
                                input logic [31:0] a, input logic [31:0] dt);
        int          n;
        int          idx;
        logic [31:0] v;
        if (is_mis(s, a)) return;
        n = nbytes(s);
        v = '0;
        for (int i = 0; i < n; i++) begin
            idx = int'((a + 32'(i)) % DEPTH);
            if (r_w) mem_m[d][idx] = 8'(dt >> (8 * (n - 1 - i)));
            else     v = (v << 8) | 32'(mem_m[d][idx]);
        end
        if (!r_w) dout_m[d] = v;
    endtask

    // One complete transaction; inputs are scrambled once the request is taken.
    task automatic access(input int d, input bit r_w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] dt);
        int w;
        bit mis;
        w   = (d == 0) ? 1 : 0;
        mis = is_mis(s, a);
        @(posedge Clk); #1;
        sel = d; en = 1'b1; rw = r_w; size = s; addr = a; din = dt;
        exp_stall = 1'b1; exp_done = 1'b0; exp_fault = 1'b0; exp_dout = dout_m[d];
        for (int k = 0; k < w + 1; k++) begin
            @(posedge Clk); #1;
            en = 1'($urandom); rw = 1'($urandom); size = 2'($urandom);
            addr = $urandom; din = $urandom;
        end
        @(posedge Clk); #1;
        model_access(d, r_w, s, a, dt);
        exp_stall = 1'b0; exp_done = 1'b1; exp_fault = mis; exp_dout = dout_m[d];
        en = 1'($urandom); rw = 1'($urandom); addr = $urandom; din = $urandom;
        @(posedge Clk); #1;
        en = 1'b0;
        exp_done = 1'b0; exp_fault = 1'b0;
    endtask

    task automatic mem_check(input int d, input string name);
        logic [7:0] act;
        int         bad;
        bad = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            act = (d == 0) ? dut_a.Memory[i] : dut_b.Memory[i];
            if (act !== mem_m[d][i] && bad < 0) bad = i;
        end
        tests++;
        if (bad >= 0) begin
            fails++;
            act = (d == 0) ? dut_a.Memory[bad] : dut_b.Memory[bad];
            $display("FAIL %s byte %02h: got %02h expected %02h", name, bad, act, mem_m[d][bad]);
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] pre;
        R = 1'b1; en = 1'b1; sel = 0; rw = 1'b0; size = 2'b10; addr = '0; din = '0;
        exp_stall = 1'b0; exp_done = 1'b0; exp_fault = 1'b0; exp_dout = '0;
        dout_m[0] = '0; dout_m[1] = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            v = 8'($urandom); dut_a.Memory[i] <= v; mem_m[0][i] = v;
            v = 8'($urandom); dut_b.Memory[i] <= v; mem_m[1][i] = v;
        end

        // Reset held two cycles with a request pending
        @(posedge Clk); #1;
        chk_en = 1'b1;
        @(posedge Clk); #1;
        R = 1'b0; en = 1'b0;
        @(posedge Clk); #1;

        // Word store / load, one wait state
        access(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        mem_check(0, "mem_after_word_store");
        check32("word_bytes_10", {dut_a.Memory[16], dut_a.Memory[17],
                                  dut_a.Memory[18], dut_a.Memory[19]}, 32'hDEADBEEF);
        access(0, 1'b0, 2'b10, 32'h10, $urandom);
        check32("load_word_10", o_dout, 32'hDEADBEEF);

        // Narrow accesses
        access(0, 1'b1, 2'b00, 32'h20, 32'h00000012);
        access(0, 1'b1, 2'b00, 32'h21, 32'h5A5A5AA5);
        mem_check(0, "mem_after_byte_stores");
        access(0, 1'b0, 2'b01, 32'h20, $urandom);
        check32("load_half_20", o_dout, 32'h000012A5);
        access(0, 1'b0, 2'b00, 32'h21, $urandom);
        check32("load_byte_21", o_dout, 32'h000000A5);

        // Zero wait states with wraparound
        access(1, 1'b1, 2'b10, 32'h000000FE, 32'hCAFEF00D);
        check32("wrap_byte_00", 32'(dut_b.Memory[0]), 32'h000000F0);
        check32("wrap_byte_01", 32'(dut_b.Memory[1]), 32'h0000000D);
        access(1, 1'b0, 2'b10, 32'hFFFF00FE, $urandom);
        check32("load_wrap_fe", o_dout, 32'hCAFEF00D);
        mem_check(1, "mem_after_wrap");

        // Reset during the wait state of a store
        @(posedge Clk); #1;
        sel = 0; en = 1'b1; rw = 1'b1; size = 2'b10; addr = 32'h40; din = 32'h11223344;
        exp_stall = 1'b1; exp_dout = dout_m[0];
        @(posedge Clk); #1;
        R = 1'b1; en = 1'b0;
        exp_stall = 1'b0;
        @(posedge Clk); #1;
        R = 1'b0;
        dout_m[0] = '0; dout_m[1] = '0; exp_dout = '0;
        @(posedge Clk); #1;
        check32("dout_after_mid_reset", o_dout, 32'h0);
        mem_check(0, "mem_after_mid_reset");

        // Misaligned word store
        pre = mem_m[0][8'h43];
        access(0, 1'b1, 2'b10, 32'h42, 32'h55667788);
        check32("misaligned_byte_43", 32'(dut_a.Memory[8'h43]),
                ALIGN ? 32'(pre) : 32'h00000066);
        mem_check(0, "mem_after_misaligned");

        // Randomized transactions on both responders
        for (int t = 0; t < 200; t++) begin
            access(int'($urandom_range(1, 0)), 1'($urandom), 2'($urandom),
                   $urandom, $urandom);
        end
        mem_check(0, "mem_final_a");
        mem_check(1, "mem_final_b");

        chk_en = 1'b0;
        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
